// File: rtl/instr_fetch.sv
// Instruction fetch unit: small program RAM, step/run triggered fetch, issue handshake and HALT.
// Optional feature: define IFETCH_JUMP_EN to make opcode 4'b1011 an internal jump (pc = ir[3:0]).
module instr_fetch #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TICK_DIV   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [15:0]           load_data,
    input  logic                  step,
    input  logic                  run,
    input  logic                  ir_ready,
    output logic [15:0]           ir,
    output logic                  ir_valid,
    output logic [DEPTH_LOG2-1:0] pc,
    output logic                  halted
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;
    localparam logic [3:0] OpHalt = 4'b1111;
`ifdef IFETCH_JUMP_EN
    localparam logic [3:0] OpJump = 4'b1011;
`endif

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

    state_e                state_q, state_d;
    logic [15:0]           mem_q [Words];
    logic [15:0]           mem_rd;
    logic [15:0]           ir_q, ir_d;
    logic [DEPTH_LOG2-1:0] pc_q, pc_d;
    logic [TICK_DIV-1:0]   tick_q, tick_d;
    logic                  step_q;
    logic                  trigger;

    // Program memory has no reset so a program survives rst and can be loaded during it.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Asynchronous read sees the pre-write word when load and FETCH collide.
    assign mem_rd  = mem_q[pc_q];
    assign trigger = (step & ~step_q) | (run & (&tick_q));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StFetch;
            end
            StFetch: begin
                if (mem_rd[15:12] == OpHalt) begin
                    state_d = StHalt;
`ifdef IFETCH_JUMP_EN
                end else if (mem_rd[15:12] == OpJump) begin
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (ir_ready) state_d = StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        ir_valid = (state_q == StIssue);
        halted   = (state_q == StHalt);
    end

`ifdef IFETCH_JUMP_EN
    logic [31:0] jump_wide;
    assign jump_wide = {28'd0, mem_rd[3:0]};
`endif

    // Datapath next-state
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        tick_d = '0;
        if (state_q == StIdle && run && !trigger) begin
            tick_d = tick_q + 1'b1;
        end
        unique case (state_q)
            StFetch: begin
                ir_d = mem_rd;
`ifdef IFETCH_JUMP_EN
                if (mem_rd[15:12] == OpJump) begin
                    pc_d = jump_wide[DEPTH_LOG2-1:0];
                end
`endif
            end
            StIssue: begin
                if (ir_ready) pc_d = pc_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            ir_q   <= '0;
            tick_q <= '0;
            step_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            tick_q <= tick_d;
            step_q <= step;
        end
    end

    assign ir = ir_q;
    assign pc = pc_q;

endmodule
